// File: rtl/msx_bus_sync_pkg.sv
// Shared MSX bus definitions: cycle types, front-end FSM states and the
// CH376 I/O port map also used by the CH376 decode.
package msxusb_pkg;

    typedef enum logic [2:0] {
        CYC_NONE,
        CYC_MEM_RD,
        CYC_MEM_WR,
        CYC_IO_RD,
        CYC_IO_WR
    } cyc_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACTIVE
    } state_t;

    localparam logic [7:0] CH376_DAT0 = 8'h10;
    localparam logic [7:0] CH376_CMD0 = 8'h11;
    localparam logic [7:0] CH376_DAT1 = 8'h20;
    localparam logic [7:0] CH376_CMD1 = 8'h21;

    function automatic logic is_ch376(input logic [7:0] a);
        return (a == CH376_DAT0) || (a == CH376_CMD0) ||
               (a == CH376_DAT1) || (a == CH376_CMD1);
    endfunction

    // Strobe vector order: {mem_rd, mem_wr, io_rd, io_wr}
    function automatic logic [3:0] cyc_stb(input cyc_t c);
        logic [3:0] s;
        s = 4'b0000;
        unique case (c)
            CYC_MEM_RD: s = 4'b1000;
            CYC_MEM_WR: s = 4'b0100;
            CYC_IO_RD:  s = 4'b0010;
            CYC_IO_WR:  s = 4'b0001;
            default:    s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/msx_bus_sync_if.sv
// Raw MSX cartridge bus plus the clean per-cycle outputs of the front-end.
interface msx_bus_sync_if;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        iorq_n;
    logic        m1_n;
    logic        rd_n;
    logic        wr_n;
    logic        sltsl_n;
    logic        mem_rd_stb;
    logic        mem_wr_stb;
    logic        io_rd_stb;
    logic        io_wr_stb;
    logic [15:0] cyc_addr;
    logic [7:0]  cyc_data;
    logic        busy;
    logic        wait_n;

    modport slave (
        input  addr, data, iorq_n, m1_n, rd_n, wr_n, sltsl_n,
        output mem_rd_stb, mem_wr_stb, io_rd_stb, io_wr_stb,
        output cyc_addr, cyc_data, busy, wait_n
    );

    modport master (
        output addr, data, iorq_n, m1_n, rd_n, wr_n, sltsl_n,
        input  mem_rd_stb, mem_wr_stb, io_rd_stb, io_wr_stb,
        input  cyc_addr, cyc_data, busy, wait_n
    );
endinterface

// File: rtl/msx_bus_sync_sync2.sv
// Parameterised-width 2-flop synchroniser; flops reset to 1 (strobes idle).
module msx_sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/msx_bus_sync.sv
// MSX cartridge bus front-end: sync, settle filter, one strobe per cycle.
// Optional CH376 WAIT generation enabled by defining MSX_BUS_WAIT_EN.
module msx_bus_sync
    import msxusb_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int WAIT_CYCLES   = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    msx_bus_sync_if.slave  bus
);
    logic [4:0]  raw;
    logic [4:0]  syn;
    logic        iorq_s, m1_s, rd_s, wr_s, sltsl_s;
    logic        io, mem, rdv, wrv, start, rel;
    cyc_t        cyc_now;

    state_t      state_q;
    cyc_t        cyc_q;
    logic [3:0]  cnt_q;
    logic [1:0]  prime_q;
    logic        rd_prev_q, wr_prev_q;
    logic [15:0] addr_q, cyc_addr_q;
    logic [7:0]  data_q, cyc_data_q;
    logic [3:0]  stb_q;
    logic        busy_q;
`ifdef MSX_BUS_WAIT_EN
    logic        wait_n_q;
    logic [7:0]  wcnt_q;
`endif

    assign raw = {bus.sltsl_n, bus.wr_n, bus.rd_n, bus.m1_n, bus.iorq_n};

    msx_sync2 #(.W(5)) u_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (raw),
        .q_o    (syn)
    );

    assign {sltsl_s, wr_s, rd_s, m1_s, iorq_s} = syn;

    assign io  = !iorq_s && m1_s;
    assign mem = !sltsl_s;
    assign rdv = !rd_s && wr_s;
    assign wrv = !wr_s && rd_s;
    assign rel = rd_s && wr_s;

    always_comb begin
        cyc_now = CYC_NONE;
        unique case (1'b1)
            io && rdv:         cyc_now = CYC_IO_RD;
            io && wrv:         cyc_now = CYC_IO_WR;
            !io && mem && rdv: cyc_now = CYC_MEM_RD;
            !io && mem && wrv: cyc_now = CYC_MEM_WR;
            default:           cyc_now = CYC_NONE;
        endcase
    end

    // A new cycle needs the active strobe to have been seen high last clock
    assign start = (rdv && (cyc_now != CYC_NONE) && rd_prev_q) ||
                   (wrv && (cyc_now != CYC_NONE) && wr_prev_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cyc_q      <= CYC_NONE;
            cnt_q      <= '0;
            prime_q    <= '0;
            rd_prev_q  <= 1'b0;
            wr_prev_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cyc_addr_q <= '0;
            cyc_data_q <= '0;
            stb_q      <= '0;
            busy_q     <= 1'b0;
`ifdef MSX_BUS_WAIT_EN
            wait_n_q   <= 1'b1;
            wcnt_q     <= '0;
`endif
        end else begin
            addr_q  <= bus.addr;
            data_q  <= bus.data;
            stb_q   <= '0;
            // Hold edge history until the sync chain no longer shows reset 1s
            prime_q <= {prime_q[0], 1'b1};
            if (prime_q[1]) begin
                rd_prev_q <= rd_s;
                wr_prev_q <= wr_s;
            end
`ifdef MSX_BUS_WAIT_EN
            if (!wait_n_q) begin
                if (wcnt_q == 8'd1) wait_n_q <= 1'b1;
                else wcnt_q <= wcnt_q - 8'd1;
            end
`endif
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SETTLE;
                        cyc_q   <= cyc_now;
                        cnt_q   <= 4'd1;
                    end
                end
                SETTLE: begin
                    if (cyc_now != cyc_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'(SETTLE_CYCLES)) begin
                        state_q    <= ACTIVE;
                        stb_q      <= cyc_stb(cyc_q);
                        busy_q     <= 1'b1;
                        cyc_addr_q <= addr_q;
                        cyc_data_q <= data_q;
`ifdef MSX_BUS_WAIT_EN
                        if ((cyc_q == CYC_IO_RD || cyc_q == CYC_IO_WR) &&
                            is_ch376(addr_q[7:0])) begin
                            wait_n_q <= 1'b0;
                            wcnt_q   <= 8'(WAIT_CYCLES);
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ACTIVE: begin
                    if (rel) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`ifdef MSX_BUS_WAIT_EN
                        wait_n_q <= 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {bus.mem_rd_stb, bus.mem_wr_stb,
            bus.io_rd_stb, bus.io_wr_stb} = stb_q;
    assign bus.cyc_addr = cyc_addr_q;
    assign bus.cyc_data = cyc_data_q;
    assign bus.busy     = busy_q;
`ifdef MSX_BUS_WAIT_EN
    assign bus.wait_n   = wait_n_q;
`else
    assign bus.wait_n   = 1'b1;
`endif
endmodule

// File: tb/tb_msx_bus_sync.sv
// Directed bench for msx_bus_sync: cycle types, latency, glitch/INTA
// rejection, reset mid-cycle and (with MSX_BUS_WAIT_EN) CH376 wait.
module tb_msx_bus_sync;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    msx_bus_sync_if bus ();

    msx_bus_sync #(
        .SETTLE_CYCLES (2),
        .WAIT_CYCLES   (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_chk = 0;
    int n_fail = 0;
    int t, first_stb, n_mrd, n_mwr, n_ird, n_iwr;
    int wait_lo, wait_first, busy_seen;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        t = 0; first_stb = -1; wait_first = -1;
        n_mrd = 0; n_mwr = 0; n_ird = 0; n_iwr = 0;
        wait_lo = 0; busy_seen = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            t++;
            n_mrd += int'(bus.mem_rd_stb);
            n_mwr += int'(bus.mem_wr_stb);
            n_ird += int'(bus.io_rd_stb);
            n_iwr += int'(bus.io_wr_stb);
            if ((bus.mem_rd_stb | bus.mem_wr_stb | bus.io_rd_stb |
                 bus.io_wr_stb) && first_stb < 0)
                first_stb = t;
            if (!bus.wait_n) begin
                wait_lo++;
                if (wait_first < 0) wait_first = t;
            end
            if (bus.busy) busy_seen++;
        end
    endtask

    task automatic idle_bus();
        bus.iorq_n = 1'b1; bus.m1_n = 1'b1; bus.rd_n = 1'b1;
        bus.wr_n = 1'b1; bus.sltsl_n = 1'b1;
    endtask

    initial begin
        idle_bus();
        bus.addr = 16'h0000;
        bus.data = 8'h00;
        clr_mon();
        tick(3);
        chk("rst_stb", {bus.mem_rd_stb, bus.mem_wr_stb,
                        bus.io_rd_stb, bus.io_wr_stb}, 4'b0000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_wait", bus.wait_n, 1'b1);
        chk("rst_addr", bus.cyc_addr, 16'h0000);
        chk("rst_data", bus.cyc_data, 8'h00);
        reset_n = 1'b1;
        tick(4);

        // I/O write to 0x11
        bus.addr = 16'h0011; bus.data = 8'hA5;
        clr_mon();
        bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick(10);
        chk("iow_lat", first_stb, 5);
        chk("iow_cnt", n_iwr, 1);
        chk("iow_oth", n_mrd + n_mwr + n_ird, 0);
        chk("iow_addr", bus.cyc_addr, 16'h0011);
        chk("iow_data", bus.cyc_data, 8'hA5);
        chk("iow_busy", bus.busy, 1'b1);
        idle_bus();
        tick(5);
        chk("iow_rel", bus.busy, 1'b0);
        chk("iow_one", n_iwr, 1);

        // Mapper write
        bus.addr = 16'h7000; bus.data = 8'h05;
        clr_mon();
        bus.sltsl_n = 1'b0; bus.wr_n = 1'b0;
        tick(8);
        chk("mw_cnt", n_mwr, 1);
        chk("mw_io", n_ird + n_iwr + n_mrd, 0);
        chk("mw_addr", bus.cyc_addr, 16'h7000);
        chk("mw_data", bus.cyc_data, 8'h05);
        idle_bus();
        tick(5);

        // One-clock glitch on rd_n
        bus.addr = 16'h6000; bus.data = 8'h77;
        clr_mon();
        bus.sltsl_n = 1'b0; bus.rd_n = 1'b0;
        tick(1);
        bus.rd_n = 1'b1;
        tick(8);
        chk("gl_stb", n_mrd + n_mwr + n_ird + n_iwr, 0);
        chk("gl_busy", busy_seen, 0);
        chk("gl_hold", bus.cyc_addr, 16'h7000);
        idle_bus();
        tick(3);

        // Interrupt acknowledge
        clr_mon();
        bus.iorq_n = 1'b0; bus.m1_n = 1'b0; bus.rd_n = 1'b0;
        tick(8);
        chk("inta_stb", n_mrd + n_mwr + n_ird + n_iwr, 0);
        idle_bus();
        tick(5);

        // rd_n and wr_n both low
        clr_mon();
        bus.sltsl_n = 1'b0; bus.rd_n = 1'b0; bus.wr_n = 1'b0;
        tick(8);
        chk("rdwr_stb", n_mrd + n_mwr + n_ird + n_iwr, 0);
        chk("rdwr_busy", busy_seen, 0);
        idle_bus();
        tick(5);

        // Memory read, data latched anyway
        bus.addr = 16'h4000; bus.data = 8'h3C;
        clr_mon();
        bus.sltsl_n = 1'b0; bus.rd_n = 1'b0;
        tick(8);
        chk("mr_lat", first_stb, 5);
        chk("mr_cnt", n_mrd, 1);
        chk("mr_data", bus.cyc_data, 8'h3C);
        idle_bus();
        tick(5);

        // io and mem together: io wins; port 0x30 never waits
        bus.addr = 16'h0030; bus.data = 8'h00;
        clr_mon();
        bus.iorq_n = 1'b0; bus.sltsl_n = 1'b0; bus.rd_n = 1'b0;
        tick(14);
        chk("both_io", n_ird, 1);
        chk("both_mem", n_mrd + n_mwr + n_iwr, 0);
        chk("p30_wait", wait_lo, 0);
        idle_bus();
        tick(5);

        // Reset mid-ACTIVE with rd_n held low
        bus.addr = 16'h8000; bus.data = 8'h11;
        clr_mon();
        bus.sltsl_n = 1'b0; bus.rd_n = 1'b0;
        tick(8);
        chk("ra_cnt", n_mrd, 1);
        chk("ra_busy", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("ra_clr_busy", bus.busy, 1'b0);
        chk("ra_clr_addr", bus.cyc_addr, 16'h0000);
        chk("ra_clr_wait", bus.wait_n, 1'b1);
        tick(2);
        reset_n = 1'b1;
        clr_mon();
        tick(10);
        chk("ra_nostb", n_mrd + n_mwr + n_ird + n_iwr, 0);
        bus.rd_n = 1'b1;
        tick(4);
        clr_mon();
        bus.rd_n = 1'b0;
        tick(8);
        chk("ra_new", n_mrd, 1);
        chk("ra_lat", first_stb, 5);
        idle_bus();
        tick(5);

        // I/O read at CH376 port 0x20
        bus.addr = 16'h0020; bus.data = 8'h00;
        clr_mon();
        bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
        tick(16);
        chk("ch_cnt", n_ird, 1);
`ifdef MSX_BUS_WAIT_EN
        chk("ch_wfirst", wait_first, 5);
        chk("ch_wlen", wait_lo, 8);
`else
        chk("ch_nowait", wait_lo, 0);
`endif
        idle_bus();
        tick(5);
        chk("end_wait", bus.wait_n, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/msx_bus_sync.md
Name: msx_bus_sync

Overview:
- Synchronous front-end that samples the asynchronous MSX cartridge bus (Z80 strobes, slot select, address, data) into the cartridge clock domain.
- Emits clean single-cycle strobes with latched address/data per bus cycle.
- Sits directly upstream of the ROM mapper (mapper register writes, bank lookups) and the CH376 I/O decode, replacing their direct use of raw strobes as clocks.

Parameters:
- SETTLE_CYCLES, 2, consecutive synchronised samples a strobe must stay asserted before the cycle is accepted (legal 1..15).
- WAIT_CYCLES, 8, clocks wait_n is held low per CH376 I/O cycle (optional feature only; legal 1..255).

Ports:
- clk  in  1  cartridge clock (≥ 4x Z80 clock)
- reset_n  in  1  asynchronous active-low reset
- addr  in  16  raw Z80 address A15..A0
- data  in  8  raw Z80 data bus (write data)
- iorq_n, m1_n, rd_n, wr_n, sltsl_n  in  1 each  raw bus strobes
- mem_rd_stb, mem_wr_stb, io_rd_stb, io_wr_stb  out  1 each  one-clock cycle strobes
- cyc_addr  out  16  address latched for current/last cycle
- cyc_data  out  8  data latched for current/last write
- busy  out  1  high from cycle acceptance until bus release
- wait_n  out  1  Z80 WAIT request, active low (feature-gated; tied 1 without it)

Behaviour:
- Reset and idle values:
  - All outputs reset to 0, except wait_n = 1.
  - FSM resets to IDLE; counters reset to 0.
- Synchronisation:
  - iorq_n, m1_n, rd_n, wr_n, sltsl_n pass through 2-flop synchronisers; synchroniser flops reset to 1.
  - addr/data are registered in one stage every clock, with no sync chain; they are stable before the strobes by the bus protocol.
- Cycle qualifiers, all on synchronised signals:
  - mem: sltsl low.
  - io: iorq low AND m1 high. Interrupt acknowledge (iorq & m1 both low) is ignored.
  - dir: rd low XOR wr low. Both low is invalid.
- FSM:
  - IDLE -> SETTLE when a qualifier and exactly one of rd/wr is asserted, the previous-sample register shows it deasserted, and the settle counter is loaded.
  - SETTLE: counter counts up each clock while the same qualifier/dir holds. If any of them changes, go to IDLE with no strobe (glitch reject). When count reaches SETTLE_CYCLES, latch cyc_addr/cyc_data from the registered buses, pulse the matching strobe for exactly 1 clock, set busy, go to ACTIVE.
  - ACTIVE: hold busy. Go to IDLE when synced rd and wr are both high; busy clears on that same clock.
- Latency: strobe asserts SETTLE_CYCLES + 3 clocks after the raw strobe falls (2 sync + 1 edge register).
- Edge-detect previous-sample registers reset to "asserted" (0). A strobe already low when reset releases therefore produces no cycle; it must first be seen high.
- Simultaneous events:
  - io and mem qualifiers both true: io wins; one cycle only, classified io.
  - rd and wr both low: no strobe; FSM waits in IDLE until the condition clears.
- At most one strobe per bus cycle; a strobe held low for any length yields one pulse.
- Reset asserted mid-cycle: immediate async clear, no strobe, no wait_n left low.
- cyc_addr/cyc_data hold their last values until the next accepted cycle. cyc_data updates on reads as well (value is don't-care for reads).

Optional Feature:
- Macro: MSX_BUS_WAIT_EN.
- Defined:
  - On acceptance of an io cycle whose cyc_addr[7:0] is 0x10, 0x11, 0x20 or 0x21, wait_n goes low on the strobe clock.
  - wait_n stays low for WAIT_CYCLES clocks via an 8-bit down-counter, then returns high.
  - Reset or bus release before expiry forces wait_n high immediately.
- Undefined: wait_n is constant 1, no counter is instantiated, and all other behaviour is unchanged.

Decomposition:
- Shared package msxusb_pkg:
  - cycle-type enum (CYC_NONE, CYC_MEM_RD, CYC_MEM_WR, CYC_IO_RD, CYC_IO_WR).
  - FSM state enum (IDLE, SETTLE, ACTIVE).
  - CH376 port constants 0x10/0x11/0x20/0x21, shared with the CH376 decode.
- One natural sub-module, msx_sync2: a parameterised-width 2-flop synchroniser with reset value 1, instantiated for the strobe vector.

Test Plan:
- I/O write: iorq_n=0, wr_n=0, addr=0x0011, data=0xA5 held 10 clocks -> io_wr_stb exactly 1 clock at clock 5 after the fall; cyc_addr=0x0011, cyc_data=0xA5; busy high until wr_n rises.
- Mapper write: sltsl_n=0, wr_n=0, addr=0x7000, data=0x05 -> one mem_wr_stb, cyc_addr=0x7000, cyc_data=0x05; no io strobe.
- Glitch: rd_n low 1 clock with sltsl_n=0, SETTLE_CYCLES=2 -> no strobe, busy stays 0, FSM back in IDLE.
- Interrupt acknowledge: iorq_n=0, m1_n=0, rd_n=0 -> no strobe. Both rd_n=0 and wr_n=0 with sltsl_n=0 -> no strobe.
- Reset: reset_n pulsed low mid-ACTIVE while rd_n stays low -> outputs 0, wait_n=1; no new strobe until rd_n goes high then low again.
- With MSX_BUS_WAIT_EN, io_rd at 0x20, WAIT_CYCLES=8 -> wait_n low exactly 8 clocks starting with the strobe clock. Same cycle at 0x30 -> wait_n stays 1.
